handshake_bcast_tx: RTL and testbench
=====================================

// Module: handshake_bcast_tx
// PURPOSE
//  Ready/valid transmitter: the driving end of the handshake / handshake_arr lanes that the RTL monitor checks.
//  Buffers words from an upstream enqueue port in a small FIFO and broadcasts each word to a per-entry mask of lanes.
//  A word retires only when every lane in its mask has handshaked.
//  Sits between the datapath and NLANES downstream consumers. Holds valid and data stable per the monitored protocol.
// PARAMETERS
//  WIDTH   5    data word width
//  DEPTH   4    FIFO entries (power of 2, >=2)
//  NLANES  3    number of downstream handshake lanes
//  STALLW  16   width of saturating stall counter
// PORTS
//  CLK                   in   1        clock, all state on posedge
//  RESET                 in   1        synchronous, active-high reset
//  enq_valid             in   1        upstream word valid
//  enq_ready             out  1        FIFO can accept (count<DEPTH and !RESET)
//  enq_data              in   WIDTH    word to send
//  enq_mask              in   NLANES   lanes that must receive the word
//  handshake_arr_valid   out  NLANES   per-lane valid
//  handshake_arr_ready   in   NLANES   per-lane ready
//  handshake_data        out  WIDTH    head word, shared by all lanes
//  fifo_count            out  $clog2(DEPTH+1)  occupied entries incl. head
//  stall_cnt             out  STALLW   cycles with any lane valid&&!ready, saturating
// BEHAVIOUR
//  Reset values: handshake_arr_valid=0, handshake_data=0, fifo_count=0, stall_cnt=0, FSM=IDLE; enq_ready=0 while RESET=1.
//  Enqueue: fires on enq_valid&&enq_ready. enq_ready depends only on registered count (no ready->ready comb path),
//   so a full FIFO refuses enq even in a cycle where the head pops. enq_mask==0: accepted and discarded, never stored.
//  Head: pending[NLANES] register; handshake_arr_valid[i]=head_present&&pending[i]; handshake_data=head word.
//  Lane handshake i: valid[i]&&ready[i] clears pending[i] at the next edge. ready on a lane not valid is ignored.
//  Retire: when (pending & ~(valid&ready))==0, pop. If another entry exists, load its word/mask into head/pending
//   in the same edge (zero bubble). One word/cycle when all masked lanes ready.
//  Latency: word enqueued into empty FIFO drives valid the next cycle. Retire needs >=1 cycle.
//  Protocol: once valid[i] rises it stays high with handshake_data unchanged until lane i handshakes; no retraction.
//  FSM: IDLE (no head) -> BCAST on head load; BCAST (pending==mask) -> PARTIAL when some, not all, lanes done;
//   BCAST/PARTIAL -> BCAST on retire with next entry, -> IDLE on retire with FIFO empty.
//  Simultaneous enq+retire: count unchanged; enq into empty FIFO while nothing pending goes straight to head next cycle.
//  Pointers wrap modulo DEPTH; count in 0..DEPTH.
//  stall_cnt saturates at 2^STALLW-1, never wraps.
//  Reset mid-transfer: all entries and pending dropped at the RESET edge; valid deasserts next cycle (only legal retraction).
// CONFIGURATION
//  HANDSHAKE_BCAST_TX_ASSERT_EN defined: embedded SVA on CLK, disabled iff RESET:
//   valid[i]&&!ready[i] |=> valid[i] && $stable(handshake_data); fifo_count<=DEPTH; no enq fire while count==DEPTH;
//   handshake_arr_valid ⊆ pending mask. A violation raises $error.
//  Undefined: no assertions compiled in; datapath and timing are identical either way.
// TESTING
//  1. Reset 2 cycles, enq 5'h0A mask 3'b111, all ready=1 -> valid=3'b111 next cycle, data=0A, retires in 1 cycle, count 1->0.
//  2. Enq 5'h11 mask 3'b101, ready=3'b001 for 3 cycles then 3'b100 -> valid 101 -> 100 -> 000; data held 11; stall_cnt=3.
//  3. Enq 5 words back-to-back with all ready=0 -> 4 accepted, enq_ready=0 at count=4; release ready=111 -> 4 pops, 1/cycle, FIFO order kept.
//  4. Full FIFO and head retiring in the same cycle with enq_valid=1 -> enq refused that cycle, accepted next; count 4->3->4.
//  5. Enq mask 3'b000 then 5'h07 mask 3'b010 -> only 07 appears, on lane 1 only; count never counts the masked-off word.
//  6. RESET pulse while head is PARTIAL with 2 entries queued -> next cycle valid=0, count=0, stall_cnt=0, FSM=IDLE; enq_ready=1 after release.

Source files
------------

// File: rtl/handshake_bcast_tx.sv
// rtl/handshake_bcast_tx.sv - FIFO-buffered ready/valid broadcaster to NLANES lanes (optional SVA: HANDSHAKE_BCAST_TX_ASSERT_EN)
module handshake_bcast_tx #(
  parameter int WIDTH  = 5,
  parameter int DEPTH  = 4,
  parameter int NLANES = 3,
  parameter int STALLW = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_data,
  input  logic [NLANES-1:0]          enq_mask,
  output logic [NLANES-1:0]          handshake_arr_valid,
  input  logic [NLANES-1:0]          handshake_arr_ready,
  output logic [WIDTH-1:0]           handshake_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [STALLW-1:0]          stall_cnt
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE = 2'd0, BCAST = 2'd1, PARTIAL = 2'd2} state_e;

  // The head entry lives in the storage at rd_ptr; pending tracks which of its lanes are still owed.
  logic [WIDTH-1:0]  data_mem_q [DEPTH];
  logic [NLANES-1:0] mask_mem_q [DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CNTW-1:0]   count_q, count_d;
  logic [NLANES-1:0] pending_q, pending_d, lane_hs;
  logic [STALLW-1:0] stall_q, stall_d;
  state_e            state_q, state_d;
  logic              head_present, enq_fire, enq_store, retire;

  // Ready depends only on registered occupancy, so a full FIFO refuses even while the head pops.
  assign enq_ready  = !RESET && (count_q < CNTW'(DEPTH));
  assign fifo_count = count_q;
  assign stall_cnt  = stall_q;

  // FSM output decode: lanes see the head only while the FSM holds one.
  always_comb begin
    head_present        = (state_q != IDLE);
    handshake_arr_valid = head_present ? pending_q : '0;
    handshake_data      = head_present ? data_mem_q[rd_ptr_q] : '0;
  end

  // Datapath next state: enqueue, per-lane completion, zero-bubble retire/reload, stall count.
  always_comb begin
    lane_hs   = handshake_arr_valid & handshake_arr_ready;
    enq_fire  = enq_valid && enq_ready;
    enq_store = enq_fire && (enq_mask != '0);
    retire    = head_present && ((pending_q & ~lane_hs) == '0);
    rd_next   = rd_ptr_q + PTRW'(1);
    wr_ptr_d  = enq_store ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d  = retire ? rd_next : rd_ptr_q;
    count_d   = count_q + CNTW'(enq_store) - CNTW'(retire);
    if (retire) begin
      if (count_q > CNTW'(1))
        pending_d = mask_mem_q[rd_next];
      else if (enq_store)
        pending_d = enq_mask;
      else
        pending_d = '0;
    end else if (!head_present) begin
      pending_d = enq_store ? enq_mask : '0;
    end else begin
      pending_d = pending_q & ~lane_hs;
    end
    if ((|(handshake_arr_valid & ~handshake_arr_ready)) && (stall_q != '1))
      stall_d = stall_q + STALLW'(1);
    else
      stall_d = stall_q;
  end

  // FSM next state: IDLE until a head loads, PARTIAL once some masked lanes are done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enq_store) state_d = BCAST;
      end
      BCAST, PARTIAL: begin
        if (retire)
          state_d = (count_d != '0) ? BCAST : IDLE;
        else if (pending_d != mask_mem_q[rd_ptr_q])
          state_d = PARTIAL;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Control registers; reset drops every queued entry and any pending lanes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      stall_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      stall_q   <= stall_d;
    end
  end

  // Entry storage; contents are only visible through a valid head, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (enq_store) begin
      data_mem_q[wr_ptr_q] <= enq_data;
      mask_mem_q[wr_ptr_q] <= enq_mask;
    end
  end

`ifdef HANDSHAKE_BCAST_TX_ASSERT_EN
  for (genvar i = 0; i < NLANES; i++) begin : g_lane_chk
    a_hold: assert property (@(posedge CLK) disable iff (RESET)
      handshake_arr_valid[i] && !handshake_arr_ready[i] |=> handshake_arr_valid[i] && $stable(handshake_data))
      else $error("lane %0d dropped valid or changed data before handshake", i);
  end
  a_count: assert property (@(posedge CLK) disable iff (RESET) count_q <= CNTW'(DEPTH))
    else $error("fifo_count above DEPTH");
  a_full: assert property (@(posedge CLK) disable iff (RESET) !(enq_fire && count_q == CNTW'(DEPTH)))
    else $error("enqueue accepted while full");
  a_subset: assert property (@(posedge CLK) disable iff (RESET) (handshake_arr_valid & ~pending_q) == '0)
    else $error("valid asserted on a lane not pending");
`else
  // Checks compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_handshake_bcast_tx.sv
// tb/tb_handshake_bcast_tx.sv - table vectors plus scoreboard bench for handshake_bcast_tx
module tb_handshake_bcast_tx;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        enq_valid;
  logic        enq_ready;
  logic [4:0]  enq_data;
  logic [2:0]  enq_mask;
  logic [2:0]  handshake_arr_valid;
  logic [2:0]  handshake_arr_ready;
  logic [4:0]  handshake_data;
  logic [2:0]  fifo_count;
  logic [15:0] stall_cnt;

  handshake_bcast_tx #(.WIDTH(5), .DEPTH(4), .NLANES(3), .STALLW(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data), .enq_mask(enq_mask),
    .handshake_arr_valid(handshake_arr_valid), .handshake_arr_ready(handshake_arr_ready),
    .handshake_data(handshake_data), .fifo_count(fifo_count), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ev;
    logic [4:0]  ed;
    logic [2:0]  em;
    logic [2:0]  rdy;
    logic [2:0]  x_valid;
    logic [4:0]  x_data;
    logic [2:0]  x_count;
    logic        x_enq_ready;
    logic [15:0] x_stall;
  } vec_t;

  typedef struct {
    logic [4:0] d;
    logic [2:0] m;
  } sb_t;

  vec_t vecs [14];
  sb_t  sbq [$];
  logic [2:0] got;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic ev, input logic [4:0] ed, input logic [2:0] em, input logic [2:0] rdy);
    enq_valid = ev;
    enq_data = ed;
    enq_mask = em;
    handshake_arr_ready = rdy;
    #1;
  endtask

  task automatic monitor();
    sb_t h;
    for (int i = 0; i < 3; i++) begin
      if (handshake_arr_valid[i]) begin
        if (sbq.size() == 0) begin
          chk("valid_with_nothing_queued", {31'd0, handshake_arr_valid[i]}, 32'd0);
        end else begin
          h = sbq[0];
          chk("lane_owed", {31'd0, h.m[i] & ~got[i]}, 32'd1);
          if (handshake_arr_ready[i]) begin
            chk("lane_data", {27'd0, handshake_data}, {27'd0, h.d});
            got[i] = 1'b1;
          end
        end
      end
    end
    if (sbq.size() > 0) begin
      h = sbq[0];
      if (got == h.m) begin
        void'(sbq.pop_front());
        got = '0;
      end
    end
  endtask

  task automatic tick();
    sb_t e;
    monitor();
    if (enq_valid && enq_ready && enq_mask != 3'b000) begin
      e.d = enq_data;
      e.m = enq_mask;
      sbq.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // ev  data    mask    ready  | valid  data   cnt  erdy  stall
    vecs[0]  = '{1'b1, 5'h0A, 3'b111, 3'b111, 3'b000, 5'h00, 3'd0, 1'b1, 16'd0};
    vecs[1]  = '{1'b0, 5'h00, 3'b000, 3'b111, 3'b111, 5'h0A, 3'd1, 1'b1, 16'd0};
    vecs[2]  = '{1'b0, 5'h00, 3'b000, 3'b111, 3'b000, 5'h00, 3'd0, 1'b1, 16'd0};
    vecs[3]  = '{1'b1, 5'h11, 3'b101, 3'b000, 3'b000, 5'h00, 3'd0, 1'b1, 16'd0};
    vecs[4]  = '{1'b0, 5'h00, 3'b000, 3'b001, 3'b101, 5'h11, 3'd1, 1'b1, 16'd0};
    vecs[5]  = '{1'b0, 5'h00, 3'b000, 3'b001, 3'b100, 5'h11, 3'd1, 1'b1, 16'd1};
    vecs[6]  = '{1'b0, 5'h00, 3'b000, 3'b001, 3'b100, 5'h11, 3'd1, 1'b1, 16'd2};
    vecs[7]  = '{1'b0, 5'h00, 3'b000, 3'b100, 3'b100, 5'h11, 3'd1, 1'b1, 16'd3};
    vecs[8]  = '{1'b0, 5'h00, 3'b000, 3'b000, 3'b000, 5'h00, 3'd0, 1'b1, 16'd3};
    vecs[9]  = '{1'b1, 5'h1F, 3'b000, 3'b000, 3'b000, 5'h00, 3'd0, 1'b1, 16'd3};
    vecs[10] = '{1'b1, 5'h07, 3'b010, 3'b000, 3'b000, 5'h00, 3'd0, 1'b1, 16'd3};
    vecs[11] = '{1'b0, 5'h00, 3'b000, 3'b000, 3'b010, 5'h07, 3'd1, 1'b1, 16'd3};
    vecs[12] = '{1'b0, 5'h00, 3'b000, 3'b010, 3'b010, 5'h07, 3'd1, 1'b1, 16'd4};
    vecs[13] = '{1'b0, 5'h00, 3'b000, 3'b000, 3'b000, 5'h00, 3'd0, 1'b1, 16'd4};

    got = '0;
    RESET = 1'b1;
    enq_valid = 1'b0;
    enq_data = '0;
    enq_mask = '0;
    handshake_arr_ready = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("reset_valid", {29'd0, handshake_arr_valid}, 32'd0);
    chk("reset_data", {27'd0, handshake_data}, 32'd0);
    chk("reset_count", {29'd0, fifo_count}, 32'd0);
    chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
    chk("reset_enq_ready", {31'd0, enq_ready}, 32'd0);
    RESET = 1'b0;

    // single-cycle broadcast, partial lanes with stalls, masked-off word
    for (int v = 0; v < 14; v++) begin
      step(vecs[v].ev, vecs[v].ed, vecs[v].em, vecs[v].rdy);
      chk($sformatf("v%0d_valid", v), {29'd0, handshake_arr_valid}, {29'd0, vecs[v].x_valid});
      chk($sformatf("v%0d_data", v), {27'd0, handshake_data}, {27'd0, vecs[v].x_data});
      chk($sformatf("v%0d_count", v), {29'd0, fifo_count}, {29'd0, vecs[v].x_count});
      chk($sformatf("v%0d_enq_ready", v), {31'd0, enq_ready}, {31'd0, vecs[v].x_enq_ready});
      chk($sformatf("v%0d_stall", v), {16'd0, stall_cnt}, {16'd0, vecs[v].x_stall});
      tick();
    end

    // fill to full with lanes blocked, then drain one word per cycle in order
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 5'h01 + 5'(k), 3'b111, 3'b000);
      chk("fill_count", {29'd0, fifo_count}, k);
      chk("fill_enq_ready", {31'd0, enq_ready}, (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    step(1'b0, 5'h00, 3'b000, 3'b000);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_valid", {29'd0, handshake_arr_valid}, 32'd7);
    tick();
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 5'h00, 3'b000, 3'b111);
      chk("drain_count", {29'd0, fifo_count}, 4 - j);
      chk("drain_data", {27'd0, handshake_data}, 1 + j);
      chk("drain_valid", {29'd0, handshake_arr_valid}, 32'd7);
      tick();
    end
    step(1'b0, 5'h00, 3'b000, 3'b000);
    chk("drained_count", {29'd0, fifo_count}, 32'd0);
    chk("drained_valid", {29'd0, handshake_arr_valid}, 32'd0);
    chk("drained_scoreboard", sbq.size(), 32'd0);

    // full FIFO with the head retiring while enq_valid is held
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 5'h08 + 5'(k), 3'b001, 3'b000);
      tick();
    end
    step(1'b1, 5'h0C, 3'b001, 3'b001);
    chk("pop_full_count", {29'd0, fifo_count}, 32'd4);
    chk("pop_full_enq_ready", {31'd0, enq_ready}, 32'd0);
    chk("pop_full_data", {27'd0, handshake_data}, 32'h08);
    tick();
    step(1'b1, 5'h0C, 3'b001, 3'b000);
    chk("after_pop_count", {29'd0, fifo_count}, 32'd3);
    chk("after_pop_enq_ready", {31'd0, enq_ready}, 32'd1);
    tick();
    step(1'b0, 5'h00, 3'b000, 3'b000);
    chk("refill_count", {29'd0, fifo_count}, 32'd4);
    tick();
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 5'h00, 3'b000, 3'b001);
      chk("refill_drain_data", {27'd0, handshake_data}, 9 + j);
      tick();
    end
    step(1'b0, 5'h00, 3'b000, 3'b000);
    chk("refill_drained_count", {29'd0, fifo_count}, 32'd0);
    chk("refill_drained_scoreboard", sbq.size(), 32'd0);

    // reset while the head is partially delivered with two entries behind it
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'h10 + 5'(2 * k), 3'b011, 3'b000);
      tick();
    end
    step(1'b0, 5'h00, 3'b000, 3'b001);
    chk("pre_rst_valid", {29'd0, handshake_arr_valid}, 32'd3);
    chk("pre_rst_count", {29'd0, fifo_count}, 32'd3);
    tick();
    RESET = 1'b1;
    step(1'b1, 5'h1F, 3'b111, 3'b000);
    chk("partial_valid", {29'd0, handshake_arr_valid}, 32'd2);
    chk("in_rst_enq_ready", {31'd0, enq_ready}, 32'd0);
    tick();
    sbq.delete();
    got = '0;
    RESET = 1'b0;
    step(1'b0, 5'h00, 3'b000, 3'b000);
    chk("post_rst_valid", {29'd0, handshake_arr_valid}, 32'd0);
    chk("post_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("post_rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("post_rst_data", {27'd0, handshake_data}, 32'd0);
    chk("post_rst_enq_ready", {31'd0, enq_ready}, 32'd1);
    tick();
    step(1'b1, 5'h15, 3'b100, 3'b000);
    tick();
    step(1'b0, 5'h00, 3'b000, 3'b100);
    chk("recover_valid", {29'd0, handshake_arr_valid}, 32'd4);
    chk("recover_data", {27'd0, handshake_data}, 32'h15);
    tick();
    step(1'b0, 5'h00, 3'b000, 3'b000);
    chk("recover_count", {29'd0, fifo_count}, 32'd0);
    chk("recover_scoreboard", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
